tt_cell_pad_ctrl: RTL and testbench

Parametrised pad-control macro for N_SIG bidirectional signal pads plus synchronous core interface, the successor to the single-signal cell macro. It holds a per-pad configuration (mode, slew, Schmitt, pulls) loaded through a valid/ready config port with atomic shadow-to-active commit. It registers core outputs toward the pads and synchronises pad inputs into the clock domain. It sits between the pad ring and the tile mux inside the top-level macro.

---
 rtl/tt_pad_pkg.sv | 30 +++
 rtl/tt_pad_sync.sv | 20 ++
 rtl/tt_cell_pad_ctrl.sv | 133 +++++++++++++
 tb/tb_tt_cell_pad_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pad_pkg.sv
// Shared types and constants for the pad-control macro: pad modes, cfg_word
// field layout, the reset configuration word and the config FSM states.
package tt_pad_pkg;

  typedef enum logic [1:0] {
    MODE_DISABLED = 2'd0,
    MODE_INPUT    = 2'd1,
    MODE_OUTPUT   = 2'd2,
    MODE_BIDIR    = 2'd3
  } pad_mode_e;

  localparam int CFG_MODE_LSB = 4;
  localparam int CFG_SL_BIT   = 3;
  localparam int CFG_CS_BIT   = 2;
  localparam int CFG_PD_BIT   = 1;
  localparam int CFG_PU_BIT   = 0;

  localparam logic [5:0] CFG_RESET = 6'b00_0010;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BREAK = 1'b1
  } cfg_state_e;

  // Enabling both pulls at once would fight inside the pad, so such words are refused.
  function automatic logic cfg_word_legal(input logic [5:0] word);
    return !(word[CFG_PD_BIT] && word[CFG_PU_BIT]);
  endfunction

endpackage

// File: rtl/tt_pad_sync.sv
// Resettable multi-flop synchroniser bringing one pad receive bit into clk.
module tt_pad_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/tt_cell_pad_ctrl.sv
// Pad-control macro: per-pad shadow/active configuration with atomic commit,
// registered core-to-pad outputs and synchronised pad-to-core inputs.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | accepting WRITE/COMMIT requests, active config steady
// ST_BREAK | one-cycle commit window; OE dropped on mode-changing pads,
//          | active loaded from shadow at the closing edge
module tt_cell_pad_ctrl
  import tt_pad_pkg::*;
#(
  parameter int N_SIG       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_op,
  input  logic [3:0]       cfg_sel,
  input  logic [5:0]       cfg_word,
  output logic             cfg_err,
  input  logic [N_SIG-1:0] core_out,
  input  logic [N_SIG-1:0] core_oe,
  output logic [N_SIG-1:0] core_in,
  input  logic [N_SIG-1:0] pad_Y,
  output logic [N_SIG-1:0] pad_A,
  output logic [N_SIG-1:0] pad_OE,
  output logic [N_SIG-1:0] pad_IE,
  output logic [N_SIG-1:0] pad_SL,
  output logic [N_SIG-1:0] pad_CS,
  output logic [N_SIG-1:0] pad_PD,
  output logic [N_SIG-1:0] pad_PU
);

  cfg_state_e       state, state_nxt;
  logic [5:0]       shadow [N_SIG];
  logic [5:0]       active [N_SIG];
  logic [N_SIG-1:0] oe_q;
  logic [N_SIG-1:0] sync_q;
  logic             write_go, commit_go, write_bad;

  assign write_bad = ({1'b0, cfg_sel} >= 5'(N_SIG)) || !cfg_word_legal(cfg_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    write_go  = 1'b0;
    commit_go = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if (cfg_op) begin
            commit_go = 1'b1;
            state_nxt = ST_BREAK;
          end else begin
            write_go = 1'b1;
          end
        end
      end
      ST_BREAK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SIG; i++) begin
        shadow[i] <= CFG_RESET;
        active[i] <= CFG_RESET;
      end
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= write_go && write_bad;
      for (int i = 0; i < N_SIG; i++) begin
        if (write_go && !write_bad && cfg_sel == 4'(i)) shadow[i] <= cfg_word;
        if (state == ST_BREAK) active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_A <= '0;
      oe_q  <= '0;
    end else begin
      pad_A <= core_out;
      oe_q  <= core_oe;
    end
  end

  always_comb begin
    pad_OE = '0;
    pad_IE = '0;
    pad_SL = '0;
    pad_CS = '0;
    pad_PD = '0;
    pad_PU = '0;
    for (int i = 0; i < N_SIG; i++) begin
      pad_IE[i] = (active[i][CFG_MODE_LSB +: 2] == MODE_INPUT) ||
                  (active[i][CFG_MODE_LSB +: 2] == MODE_BIDIR);
      pad_OE[i] = (active[i][CFG_MODE_LSB +: 2] == MODE_OUTPUT) ||
                  ((active[i][CFG_MODE_LSB +: 2] == MODE_BIDIR) && oe_q[i]);
      // Pads about to change mode are released for the break cycle so the old
      // and new driver never overlap; untouched pads keep driving.
      if (state == ST_BREAK &&
          active[i][CFG_MODE_LSB +: 2] != shadow[i][CFG_MODE_LSB +: 2])
        pad_OE[i] = 1'b0;
      pad_SL[i] = active[i][CFG_SL_BIT];
      pad_CS[i] = active[i][CFG_CS_BIT];
      pad_PD[i] = active[i][CFG_PD_BIT];
      pad_PU[i] = active[i][CFG_PU_BIT];
    end
  end

  for (genvar g = 0; g < N_SIG; g++) begin : g_sync
    tt_pad_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pad_Y[g]),
      .q     (sync_q[g])
    );
  end

  assign core_in = sync_q & pad_IE;

endmodule

// File: tb/tb_tt_cell_pad_ctrl.sv
// Self-checking bench for tt_cell_pad_ctrl with a transaction-level model of
// the shadow/active configuration, commit break and I/O latencies.
module tb_tt_cell_pad_ctrl;
  localparam int N  = 4;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_valid = 1'b0, cfg_op = 1'b0;
  logic [3:0]   cfg_sel = '0;
  logic [5:0]   cfg_word = '0;
  logic         cfg_ready, cfg_err;
  logic [N-1:0] core_out = '0, core_oe = '0, pad_Y = '0;
  logic [N-1:0] core_in, pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU;

  int tests = 0;
  int fails = 0;

  // Model: configuration tables, commit-in-progress flag, last captured core
  // outputs and a history of pad_Y samples (index 0 = most recent edge).
  logic [5:0]   m_sh [N];
  logic [5:0]   m_ac [N];
  logic         m_break, m_err;
  logic [N-1:0] m_a, m_oe;
  logic [N-1:0] m_y [SS];

  logic [33:0] got;
  assign got = {pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU, core_in, cfg_ready, cfg_err};

  tt_cell_pad_ctrl #(.N_SIG(N), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_op(cfg_op), .cfg_sel(cfg_sel), .cfg_word(cfg_word), .cfg_err(cfg_err),
    .core_out(core_out), .core_oe(core_oe), .core_in(core_in), .pad_Y(pad_Y),
    .pad_A(pad_A), .pad_OE(pad_OE), .pad_IE(pad_IE), .pad_SL(pad_SL),
    .pad_CS(pad_CS), .pad_PD(pad_PD), .pad_PU(pad_PU)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sh[i] = 6'b00_0010;
      m_ac[i] = 6'b00_0010;
    end
    for (int k = 0; k < SS; k++) m_y[k] = '0;
    m_break = 1'b0;
    m_err   = 1'b0;
    m_a     = '0;
    m_oe    = '0;
  endtask

  function automatic logic [33:0] exp_vec();
    logic [N-1:0] oe, ie, sl, cs, pd, pu;
    logic [1:0]   md;
    oe = '0; ie = '0; sl = '0; cs = '0; pd = '0; pu = '0;
    for (int i = 0; i < N; i++) begin
      md    = m_ac[i][5:4];
      ie[i] = (md == 2'd1) || (md == 2'd3);
      oe[i] = (md == 2'd2) || (md == 2'd3 && m_oe[i]);
      if (m_break && md != m_sh[i][5:4]) oe[i] = 1'b0;
      sl[i] = m_ac[i][3];
      cs[i] = m_ac[i][2];
      pd[i] = m_ac[i][1];
      pu[i] = m_ac[i][0];
    end
    return {m_a, oe, ie, sl, cs, pd, pu, m_y[SS-1] & ie, !m_break, m_err};
  endfunction

  // Advance one clock: capture inputs, wait for the edge, then apply the
  // behavioural rules for that edge to the model.
  task automatic cyc();
    logic         v  = cfg_valid;
    logic         op = cfg_op;
    logic [3:0]   sl = cfg_sel;
    logic [5:0]   w  = cfg_word;
    logic [N-1:0] co = core_out;
    logic [N-1:0] ce = core_oe;
    logic [N-1:0] y  = pad_Y;
    logic         acc, bad;
    @(posedge clk);
    #1;
    acc   = v && !m_break;
    bad   = (int'(sl) >= N) || (w[1] && w[0]);
    m_err = acc && !op && bad;
    if (m_break) begin
      for (int i = 0; i < N; i++) m_ac[i] = m_sh[i];
      m_break = 1'b0;
    end else if (acc && op) begin
      m_break = 1'b1;
    end
    if (acc && !op && !bad) m_sh[int'(sl)] = w;
    m_a  = co;
    m_oe = ce;
    for (int k = SS - 1; k > 0; k--) m_y[k] = m_y[k-1];
    m_y[0] = y;
  endtask

  task automatic cfg_req(input logic op, input logic [3:0] sel, input logic [5:0] word);
    cfg_valid = 1'b1;
    cfg_op    = op;
    cfg_sel   = sel;
    cfg_word  = word;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [33:0] rv;
    rv = {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0};
    rst_n = 1'b0;
    model_reset();
    #12;
    tests++;
    if (got !== rv) begin
      fails++;
      $display("FAIL reset_hold: got %h expected %h", got, rv);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      tests++;
      if (got !== rv) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: got %h expected %h", c, got, rv);
      end
    end
  endtask

  task automatic test_output_ch1();
    core_out = 4'b0010;
    cfg_req(1'b0, 4'd1, 6'b10_0000);
    tests++;
    if (got !== exp_vec()) begin
      fails++;
      $display("FAIL out_write: got %h expected %h", got, exp_vec());
    end
    cfg_req(1'b1, 4'd0, 6'd0);
    tests++;
    if (pad_OE[1] !== 1'b0 || cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL out_break: oe1=%b ready=%b expected 0 0", pad_OE[1], cfg_ready);
    end
    cyc();
    tests++;
    if (pad_OE[1] !== 1'b1 || pad_A[1] !== 1'b1 || pad_PD[1] !== 1'b0 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL out_live: oe1=%b a1=%b pd1=%b ready=%b expected 1 1 0 1",
               pad_OE[1], pad_A[1], pad_PD[1], cfg_ready);
    end
    tests++;
    if (got !== exp_vec()) begin
      fails++;
      $display("FAIL out_all: got %h expected %h", got, exp_vec());
    end
  endtask

  task automatic test_input_ch2();
    pad_Y[2] = 1'b0;
    cfg_req(1'b0, 4'd2, 6'b01_0001);
    cfg_req(1'b1, 4'd0, 6'd0);
    for (int c = 0; c < 3; c++) cyc();
    pad_Y[2] = 1'b1;
    cyc();
    tests++;
    if (core_in[2] !== 1'b0) begin
      fails++;
      $display("FAIL in_early: core_in2=%b expected 0", core_in[2]);
    end
    cyc();
    tests++;
    if (core_in[2] !== 1'b1 || pad_PU[2] !== 1'b1) begin
      fails++;
      $display("FAIL in_sync: core_in2=%b pu2=%b expected 1 1", core_in[2], pad_PU[2]);
    end
    cfg_req(1'b0, 4'd2, 6'b00_0010);
    cfg_req(1'b1, 4'd0, 6'd0);
    cyc();
    tests++;
    if (core_in[2] !== 1'b0 || got !== exp_vec()) begin
      fails++;
      $display("FAIL in_disabled: core_in2=%b expected 0, got %h expected %h",
               core_in[2], got, exp_vec());
    end
  endtask

  task automatic test_bidir();
    cfg_req(1'b0, 4'd0, 6'b11_0000);
    cfg_req(1'b0, 4'd3, 6'b01_0010);
    cfg_req(1'b1, 4'd0, 6'd0);
    cyc();
    for (int c = 0; c < 10; c++) begin
      core_oe[0] = c[0];
      core_out   = 4'($urandom);
      if (c == 4) begin
        cfg_valid = 1'b1;
        cfg_op    = 1'b1;
      end else begin
        cfg_valid = 1'b0;
      end
      cyc();
      tests++;
      if (pad_OE[0] !== c[0] || got !== exp_vec()) begin
        fails++;
        $display("FAIL bidir cyc%0d: oe0=%b expected %b, got %h expected %h",
                 c, pad_OE[0], c[0], got, exp_vec());
      end
    end
    cfg_valid = 1'b0;
    tests++;
    if (pad_IE[3] !== 1'b1) begin
      fails++;
      $display("FAIL bidir_ch3: ie3=%b expected 1", pad_IE[3]);
    end
  endtask

  task automatic test_reject();
    cfg_req(1'b0, 4'd9, 6'b10_0000);
    tests++;
    if (cfg_err !== 1'b1) begin
      fails++;
      $display("FAIL rej_sel: cfg_err=%b expected 1", cfg_err);
    end
    cyc();
    tests++;
    if (cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL rej_pulse: cfg_err=%b expected 0", cfg_err);
    end
    cfg_req(1'b0, 4'd1, 6'b11_0011);
    tests++;
    if (cfg_err !== 1'b1) begin
      fails++;
      $display("FAIL rej_pull: cfg_err=%b expected 1", cfg_err);
    end
    cfg_req(1'b1, 4'd0, 6'd0);
    cyc();
    tests++;
    if (got !== exp_vec() || pad_OE[1] !== 1'b1 || pad_PD[1] !== 1'b0) begin
      fails++;
      $display("FAIL rej_commit: got %h expected %h", got, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      cfg_valid = 1'b1;
      cfg_op    = 1'b0;
      cfg_sel   = 4'(c);
      cfg_word  = {2'(c), 4'b1010};
      cyc();
      tests++;
      if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
        fails++;
        $display("FAIL b2b cyc%0d: ready=%b err=%b expected 1 0", c, cfg_ready, cfg_err);
      end
    end
    cfg_req(1'b1, 4'd0, 6'd0);
    cyc();
    tests++;
    if (got !== exp_vec() || pad_SL !== 4'hF) begin
      fails++;
      $display("FAIL b2b_commit: got %h expected %h", got, exp_vec());
    end
  endtask

  task automatic test_reset_break();
    logic [33:0] rv;
    rv = {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0};
    core_out = 4'hF;
    cfg_req(1'b0, 4'd2, 6'b10_0000);
    cfg_req(1'b1, 4'd0, 6'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (got !== rv) begin
      fails++;
      $display("FAIL rst_break: got %h expected %h", got, rv);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cfg_req(1'b1, 4'd0, 6'd0);
    for (int c = 0; c < 3; c++) begin
      cyc();
      tests++;
      if (pad_OE !== 4'h0 || got !== exp_vec()) begin
        fails++;
        $display("FAIL rst_after cyc%0d: got %h expected %h", c, got, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_op    = ($urandom_range(0, 3) == 0);
      cfg_sel   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      cfg_word  = 6'($urandom);
      core_out  = 4'($urandom);
      core_oe   = 4'($urandom);
      pad_Y     = 4'($urandom);
      cyc();
      tests++;
      if (got !== exp_vec()) begin
        fails++;
        errs++;
        if (errs < 10) $display("FAIL random cyc%0d: got %h expected %h", c, got, exp_vec());
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_output_ch1();
    test_input_ch2();
    test_bidir();
    test_reject();
    test_back_to_back();
    test_reset_break();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
